// File: rtl/seqdet_pkg.sv
// Elaboration-time KMP helpers shared by the sequence detector.
// Pattern bit 0 of the prefix is the MSB of the LEN-bit pattern value.
package seqdet_pkg;

  localparam int unsigned MAX_LEN = 16;

  typedef logic [4:0]            fail_t;
  typedef fail_t [MAX_LEN:0]     fail_arr_t;

  // i-th received-order bit of the pattern (i = 0 is the first bit on the wire)
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] pat,
                                   input int unsigned len,
                                   input int unsigned i);
    logic [MAX_LEN-1:0] sh;
    sh = pat >> (len - 1 - i);
    return sh[0];
  endfunction

  // f[k] = longest proper border of the length-k prefix, k = 0..len
  function automatic fail_arr_t kmp_fail(input logic [MAX_LEN-1:0] pat,
                                         input int unsigned len);
    fail_arr_t   f;
    int unsigned k;
    f = '0;
    k = 0;
    for (int unsigned i = 1; i < len; i++) begin
      for (int unsigned j = 0; j < MAX_LEN; j++) begin
        if (k > 0 && pat_bit(pat, len, i) != pat_bit(pat, len, k))
          k = {27'b0, f[k[4:0]]};
      end
      if (pat_bit(pat, len, i) == pat_bit(pat, len, k))
        k++;
      f[i[4:0] + 5'd1] = k[4:0];
    end
    return f;
  endfunction

  function automatic int unsigned kmp_border(input logic [MAX_LEN-1:0] pat,
                                             input int unsigned len);
    fail_arr_t   f;
    int unsigned idx;
    f   = kmp_fail(pat, len);
    idx = len;
    return {27'b0, f[idx[4:0]]};
  endfunction

  // Longest prefix that is a suffix of (prefix_s, b); returns len on a full match
  function automatic int unsigned kmp_next(input logic [MAX_LEN-1:0] pat,
                                           input int unsigned len,
                                           input int unsigned s,
                                           input logic b);
    fail_arr_t   f;
    int unsigned m;
    int unsigned res;
    logic        done;
    f    = kmp_fail(pat, len);
    m    = s;
    res  = 0;
    done = 1'b0;
    for (int unsigned j = 0; j <= MAX_LEN; j++) begin
      if (!done) begin
        if (m < len && pat_bit(pat, len, m) == b) begin
          res  = m + 1;
          done = 1'b1;
        end else if (m == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          m = {27'b0, f[m[4:0]]};
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seqdet_next_state.sv
// Combinational (state, bit) -> (next_state, hit) map, folded to constants per PATTERN.
module seqdet_next_state
  import seqdet_pkg::*;
#(
  parameter int unsigned    LEN     = 5,
  parameter logic [LEN-1:0] PATTERN = 5'b10110,
  parameter int unsigned    SW      = $clog2(LEN + 1)
) (
  input  logic [SW-1:0] state,
  input  logic          data_bit,
  output logic [SW-1:0] next_state,
  output logic          hit
);

  localparam int unsigned BORDER = kmp_border(MAX_LEN'(PATTERN), LEN);

  logic [SW-1:0] lut0 [2**SW];
  logic [SW-1:0] lut1 [2**SW];
  logic [SW-1:0] m;

  // Unreachable codes (>= LEN) map to 0 so the select is a full decode of state
  for (genvar s = 0; s < 2**SW; s++) begin : g_state
    if (s < LEN) begin : g_live
      localparam int unsigned M0 = kmp_next(MAX_LEN'(PATTERN), LEN, s, 1'b0);
      localparam int unsigned M1 = kmp_next(MAX_LEN'(PATTERN), LEN, s, 1'b1);
      assign lut0[s] = SW'(M0);
      assign lut1[s] = SW'(M1);
    end else begin : g_dead
      assign lut0[s] = '0;
      assign lut1[s] = '0;
    end
  end

  assign m          = data_bit ? lut1[state] : lut0[state];
  assign hit        = (m == SW'(LEN));
  assign next_state = hit ? SW'(BORDER) : m;

endmodule

// File: rtl/sequence_detector.sv
// Serial pattern detector (KMP Moore FSM) with one-cycle registered match pulse.
// Define SEQDET_MATCH_COUNT_EN to add the saturating 16-bit match_count output.
module sequence_detector
  import seqdet_pkg::*;
#(
  parameter int unsigned    LEN     = 5,
  parameter logic [LEN-1:0] PATTERN = 5'b10110,
  parameter int unsigned    SW      = $clog2(LEN + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in,
  output logic        detected
`ifdef SEQDET_MATCH_COUNT_EN
  ,
  output logic [15:0] match_count
`endif
);

  logic [SW-1:0] state;
  logic [SW-1:0] next_state;
  logic          hit;

  seqdet_next_state #(
    .LEN     (LEN),
    .PATTERN (PATTERN),
    .SW      (SW)
  ) u_next (
    .state      (state),
    .data_bit   (data_in),
    .next_state (next_state),
    .hit        (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= '0;
      detected <= 1'b0;
    end else begin
      state    <= next_state;
      detected <= hit;
    end
  end

`ifdef SEQDET_MATCH_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (hit && match_count != '1) begin
      match_count <= match_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Self-checking bench for sequence_detector (LEN=5, PATTERN=10110).
module tb_sequence_detector;

  logic        clk;
  logic        reset;
  logic        data_in;
  logic        detected;
`ifdef SEQDET_MATCH_COUNT_EN
  logic [15:0] match_count;
`endif

  int unsigned checks;
  int unsigned errors;

  // Reference model: history of received bits since reset
  logic [4:0]  ref_sr;
  int unsigned ref_nbits;
  logic        ref_det;
  int unsigned ref_cnt;

  typedef struct {
    string       name;
    logic [15:0] bits;
    logic [15:0] exp;
    int unsigned n;
  } seq_t;

  seq_t tbl [4];

  sequence_detector #(
    .LEN     (5),
    .PATTERN (5'b10110)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .detected    (detected)
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_sr    = '0;
    ref_nbits = 0;
    ref_det   = 1'b0;
    ref_cnt   = 0;
  endtask

  task automatic model_push(input logic b);
    ref_sr    = {ref_sr[3:0], b};
    ref_nbits = ref_nbits + 1;
    ref_det   = (ref_nbits >= 5) && (ref_sr == 5'b10110);
    if (ref_det && ref_cnt < 65535) ref_cnt = ref_cnt + 1;
  endtask

  task automatic check_count(input string name);
`ifdef SEQDET_MATCH_COUNT_EN
    check(name, match_count, ref_cnt[15:0]);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // Drive one bit mid-cycle, sample #1 after the edge, compare against the model
  task automatic apply_bit(input logic b, input string tag);
    @(negedge clk);
    data_in = b;
    model_push(b);
    @(posedge clk);
    #1;
    check({tag, ".model"}, {15'b0, detected}, {15'b0, ref_det});
    check_count({tag, ".cnt"});
  endtask

  // Async reset pulse between edges; caller is at posedge+1
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check({tag, ".det"},   {15'b0, detected},  16'h0);
    check({tag, ".state"}, 16'(dut.state),     16'h0);
    check_count({tag, ".cnt"});
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] tmp_b;
    logic [15:0] tmp_e;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    data_in = 1'b0;
    model_reset();

    tbl[0] = '{name: "exact",     bits: 16'b1011000,    exp: 16'b0000100,    n: 7};
    tbl[1] = '{name: "overlap",   bits: 16'b1011011000, exp: 16'b0000100100, n: 10};
    tbl[2] = '{name: "fallback",  bits: 16'b101011000,  exp: 16'b000000100,  n: 9};
    tbl[3] = '{name: "fallback2", bits: 16'b11011000,   exp: 16'b00000100,   n: 8};

    // Reset held with random data: outputs stay cleared
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_hold.det",   {15'b0, detected}, 16'h0);
      check("rst_hold.state", 16'(dut.state),    16'h0);
      check_count("rst_hold.cnt");
    end
    reset = 1'b0;
    apply_bit(1'b0, "first_edge");
    check("first_edge.det", {15'b0, detected}, 16'h0);

    // Table-driven sequences, MSB of bits is sent first
    for (int t = 0; t < 4; t++) begin
      for (int i = int'(tbl[t].n) - 1; i >= 0; i--) begin
        tmp_b = tbl[t].bits >> i;
        tmp_e = tbl[t].exp >> i;
        apply_bit(tmp_b[0], tbl[t].name);
        check({tbl[t].name, ".tbl"}, {15'b0, detected}, {15'b0, tmp_e[0]});
      end
    end

    // Async reset clears a live pulse immediately
    apply_bit(1'b1, "pulse");
    apply_bit(1'b0, "pulse");
    apply_bit(1'b1, "pulse");
    apply_bit(1'b1, "pulse");
    apply_bit(1'b0, "pulse");
    check("pulse.hi", {15'b0, detected}, 16'h1);
    reset_pulse("pulse_rst");

    // Reset mid-pattern discards the partial match
    apply_bit(1'b1, "mid");
    apply_bit(1'b0, "mid");
    apply_bit(1'b1, "mid");
    apply_bit(1'b1, "mid");
    reset_pulse("mid_rst");
    apply_bit(1'b0, "mid_tail");
    check("mid_tail.no_pulse", {15'b0, detected}, 16'h0);
    apply_bit(1'b1, "mid_again");
    apply_bit(1'b0, "mid_again");
    apply_bit(1'b1, "mid_again");
    apply_bit(1'b1, "mid_again");
    apply_bit(1'b0, "mid_again");
    check("mid_again.pulse", {15'b0, detected}, 16'h1);

    // Random soak against the shift-register model
    for (int i = 0; i < 300; i++) begin
      apply_bit(1'($urandom_range(0, 1)), "soak");
    end
    check_count("final.cnt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
